// File: rtl/mskaes_shares_out_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : mskaes_shares_out_checker_if
// Purpose : Bundles the expected-value stream and the masked core's shared
//           output handshake seen by mskaes_shares_out_checker.
// Signals : exp_valid/exp_ready/exp_data - expected unmasked block stream
//           dut_valid/dut_ready/sh_data  - core output stream, D shares,
//                                          bit b of share s at b*D+s
// Modports: master - stimulus side (expected source and masked core)
//           slave  - the checker
// Revision: 1.0 - initial release
// ============================================================================
interface mskaes_shares_out_checker_if #(
  parameter int D = 2,
  parameter int W = 128
) ();
  logic             exp_valid;
  logic             exp_ready;
  logic [W-1:0]     exp_data;
  logic             dut_valid;
  logic             dut_ready;
  logic [W*D-1:0]   sh_data;

  modport master (
    output exp_valid, exp_data, dut_valid, sh_data,
    input  exp_ready, dut_ready
  );

  modport slave (
    input  exp_valid, exp_data, dut_valid, sh_data,
    output exp_ready, dut_ready
  );
endinterface
`default_nettype wire

// File: rtl/mskaes_shares_out_checker.sv
`default_nettype none
// ============================================================================
// Module  : mskaes_shares_out_checker
// Purpose : Output scoreboard for masked AES cores. Expected blocks are
//           queued in a FIFO; each accepted core output is recombined from
//           its D shares and compared with the FIFO head. Passes and
//           failures are counted, the first failure is captured, and the
//           checker can halt on the first mismatch. The core's out_ready is
//           throttled with a selectable back-pressure pattern.
// Ports   : clk                - clock
//           rst_n              - asynchronous active-low reset
//           i_clear            - synchronous soft clear
//           bus                - expected/core handshake (slave modport)
//           o_pass_cnt         - matching blocks (saturating)
//           o_fail_cnt         - mismatching blocks (saturating)
//           o_err              - sticky mismatch flag
//           o_first_fail_idx   - index of the first mismatching block
//           o_first_fail_data  - recombined value of the first mismatch
//           o_halted           - checker stopped after a mismatch
// Revision: 1.0 - initial release
// ============================================================================
module mskaes_shares_out_checker #(
  parameter int          D            = 2,
  parameter int          W            = 128,
  parameter int          DEPTH        = 4,
  parameter int          RDY_MODE     = 1,
  parameter int          RDY_PERIOD   = 3,
  parameter logic [31:0] LFSR_SEED    = 32'h1,
  parameter int          CNT_W        = 16,
  parameter int          STOP_ON_FAIL = 1
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    i_clear,
  mskaes_shares_out_checker_if.slave   bus,
  output logic [CNT_W-1:0]             o_pass_cnt,
  output logic [CNT_W-1:0]             o_fail_cnt,
  output logic                         o_err,
  output logic [CNT_W-1:0]             o_first_fail_idx,
  output logic [W-1:0]                 o_first_fail_data,
  output logic                         o_halted
);

  localparam int             AW        = $clog2(DEPTH);
  localparam int             PW        = (RDY_PERIOD > 1) ? $clog2(RDY_PERIOD) : 1;
  localparam logic [AW:0]    c_ptr_one = (AW+1)'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [PW-1:0]  c_pcnt_last = PW'(RDY_PERIOD - 1);
  localparam logic [31:0]    c_lfsr_taps = 32'h8020_0003;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_mem [DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic [31:0]        r_lfsr;
  logic [PW-1:0]      r_pcnt;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_fail_cnt;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_ff_idx;
  logic [W-1:0]       r_ff_data;
  logic               r_err;

  logic               w_empty;
  logic               w_full;
  logic               w_halted;
  logic               w_gate;
  logic               w_exp_ready;
  logic               w_dut_ready;
  logic               w_push;
  logic               w_fire;
  logic [W-1:0]       w_rec;
  logic [W-1:0]       w_head;
  logic               w_mismatch;

  // Pointers carry one wrap bit so that full and empty are distinguishable.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_halted = (r_state == ST_HALT);

  // Ready gating uses the current full flag only: a pop in the same cycle
  // does not open a slot for a push.
  assign w_exp_ready = !w_full && !w_halted && !i_clear;
  assign w_push      = bus.exp_valid && w_exp_ready;

  generate
    if (RDY_MODE == 0) begin : g_rdy_always
      assign w_gate = 1'b1;
    end else if (RDY_MODE == 1) begin : g_rdy_lfsr
      assign w_gate = r_lfsr[0];
    end else begin : g_rdy_period
      assign w_gate = (r_pcnt == c_pcnt_last);
    end
  endgenerate

  // The core is only drained when an expected value is available to check it.
  assign w_dut_ready = w_gate && !w_empty && !w_halted && !i_clear;
  assign w_fire      = bus.dut_valid && w_dut_ready;

  // Share s of bit b sits at b*D+s, so each bit's shares are contiguous.
  generate
    for (genvar b = 0; b < W; b++) begin : g_rec
      assign w_rec[b] = ^bus.sh_data[b*D +: D];
    end
  endgenerate

  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_mismatch = (w_rec != w_head);

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= bus.exp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_fire) r_rptr <= r_rptr + c_ptr_one;
    end
  end

  // Galois LFSR and period counter free-run every cycle, including in HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
      r_pcnt <= '0;
    end else if (i_clear) begin
      r_lfsr <= LFSR_SEED;
      r_pcnt <= '0;
    end else begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_taps) : (r_lfsr >> 1);
      r_pcnt <= (r_pcnt == c_pcnt_last) ? '0 : r_pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_idx      <= '0;
      r_ff_idx   <= '0;
      r_ff_data  <= '0;
      r_err      <= 1'b0;
    end else if (i_clear) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_idx      <= '0;
      r_ff_idx   <= '0;
      r_ff_data  <= '0;
      r_err      <= 1'b0;
    end else if (w_fire) begin
      r_idx <= (r_idx == c_cnt_max) ? r_idx : r_idx + c_cnt_one;
      if (w_mismatch) begin
        r_fail_cnt <= (r_fail_cnt == c_cnt_max) ? r_fail_cnt : r_fail_cnt + c_cnt_one;
        // Only the first mismatch is captured; err doubles as the "captured" flag.
        if (!r_err) begin
          r_err     <= 1'b1;
          r_ff_idx  <= r_idx;
          r_ff_data <= w_rec;
        end
      end else begin
        r_pass_cnt <= (r_pass_cnt == c_cnt_max) ? r_pass_cnt : r_pass_cnt + c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_fire && w_mismatch && (STOP_ON_FAIL != 0)) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    if (i_clear) w_state_nxt = ST_RUN;
  end

  assign bus.exp_ready      = w_exp_ready;
  assign bus.dut_ready      = w_dut_ready;
  assign o_pass_cnt         = r_pass_cnt;
  assign o_fail_cnt         = r_fail_cnt;
  assign o_err              = r_err;
  assign o_first_fail_idx   = r_ff_idx;
  assign o_first_fail_data  = r_ff_data;
  assign o_halted           = w_halted;

endmodule
`default_nettype wire
